mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 140 ++++++++++++++
 tb/tb_mem_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory access stage: drives the asynchronous data memory for loads and
// stores, aligns/extends load data and registers the MEM/WB results.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] d_mem_i,
  input  logic        mem_re_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  mem_f3_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_we_i,
  input  logic        stall_i,
  output logic [31:0] d_mem_addr_o,
  output logic [31:0] d_mem_wdata_o,
  output logic [3:0]  d_mem_be_o,
  output logic        d_mem_re_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  rd_o,
  output logic        reg_we_o,
  output logic        misalign_o
);

  logic [1:0]  off;
  logic [3:0]  st_be;
  logic        st_bad;
  logic [31:0] ld_data;
  logic        ld_bad;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        misalign;
  logic [31:0] wb_data_d, wb_data_q;
  logic [4:0]  rd_d, rd_q;
  logic        reg_we_d, reg_we_q;
  logic        misalign_d, misalign_q;

  assign off          = alu_i[1:0];
  assign d_mem_addr_o = {alu_i[31:2], 2'b00};
  // A store wins over a simultaneous load, so the read strobe is masked.
  assign d_mem_re_o   = mem_re_i & ~mem_wr_i;

  // Store lane replication and byte enables by access size.
  always_comb begin
    d_mem_wdata_o = wdata_i;
    st_be         = 4'b0000;
    st_bad        = 1'b0;
    case (mem_f3_i)
      3'b000: begin
        d_mem_wdata_o = {4{wdata_i[7:0]}};
        st_be         = 4'b0001 << off;
      end
      3'b001: begin
        d_mem_wdata_o = {2{wdata_i[15:0]}};
        st_be         = 4'b0011 << {alu_i[1], 1'b0};
        st_bad        = alu_i[0];
      end
      3'b010: begin
        d_mem_wdata_o = wdata_i;
        st_be         = 4'b1111;
        st_bad        = (off != 2'b00);
      end
      default: begin
        st_be  = 4'b0000;
        st_bad = 1'b1;
      end
    endcase
  end

  // Enables are suppressed while stalled so a held instruction never writes twice.
  assign d_mem_be_o = (mem_wr_i & ~stall_i & ~st_bad) ? st_be : 4'b0000;

  // Byte and halfword selection from the returned memory word.
  always_comb begin
    ld_byte = d_mem_i[7:0];
    case (off)
      2'd0:    ld_byte = d_mem_i[7:0];
      2'd1:    ld_byte = d_mem_i[15:8];
      2'd2:    ld_byte = d_mem_i[23:16];
      default: ld_byte = d_mem_i[31:24];
    endcase
    ld_half = alu_i[1] ? d_mem_i[31:16] : d_mem_i[15:0];
  end

  // Load sign/zero extension; misaligned or undefined sizes return zero.
  always_comb begin
    ld_data = 32'h0;
    ld_bad  = 1'b0;
    case (mem_f3_i)
      3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_data = {24'h0, ld_byte};
      3'b001: begin
        ld_bad  = alu_i[0];
        ld_data = alu_i[0] ? 32'h0 : {{16{ld_half[15]}}, ld_half};
      end
      3'b101: begin
        ld_bad  = alu_i[0];
        ld_data = alu_i[0] ? 32'h0 : {16'h0, ld_half};
      end
      3'b010: begin
        ld_bad  = (off != 2'b00);
        ld_data = (off != 2'b00) ? 32'h0 : d_mem_i;
      end
      default: begin
        ld_bad  = 1'b1;
        ld_data = 32'h0;
      end
    endcase
  end

  // Next-state selection for the MEM/WB register.
  always_comb begin
    misalign   = mem_wr_i ? st_bad : (mem_re_i ? ld_bad : 1'b0);
    wb_data_d  = d_mem_re_o ? ld_data : alu_i;
    rd_d       = rd_i;
    reg_we_d   = reg_we_i & ~misalign;
    misalign_d = misalign & (mem_re_i | mem_wr_i);
  end

  // MEM/WB register: holds under stall, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_q  <= 32'h0;
      rd_q       <= 5'h0;
      reg_we_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else if (!stall_i) begin
      wb_data_q  <= wb_data_d;
      rd_q       <= rd_d;
      reg_we_q   <= reg_we_d;
      misalign_q <= misalign_d;
    end
  end

  assign wb_data_o  = wb_data_q;
  assign rd_o       = rd_q;
  assign reg_we_o   = reg_we_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_i, wdata_i, d_mem_i;
  logic        mem_re_i, mem_wr_i;
  logic [2:0]  mem_f3_i;
  logic [4:0]  rd_i;
  logic        reg_we_i, stall_i;
  logic [31:0] d_mem_addr_o, d_mem_wdata_o, wb_data_o;
  logic [3:0]  d_mem_be_o;
  logic        d_mem_re_o;
  logic [4:0]  rd_o;
  logic        reg_we_o, misalign_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .alu_i(alu_i), .wdata_i(wdata_i), .d_mem_i(d_mem_i),
    .mem_re_i(mem_re_i), .mem_wr_i(mem_wr_i), .mem_f3_i(mem_f3_i),
    .rd_i(rd_i), .reg_we_i(reg_we_i), .stall_i(stall_i),
    .d_mem_addr_o(d_mem_addr_o), .d_mem_wdata_o(d_mem_wdata_o),
    .d_mem_be_o(d_mem_be_o), .d_mem_re_o(d_mem_re_o),
    .wb_data_o(wb_data_o), .rd_o(rd_o), .reg_we_o(reg_we_o),
    .misalign_o(misalign_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] dm,
                       input logic re, input logic wr, input logic [2:0] f3,
                       input logic [4:0] rd, input logic we, input logic st);
    @(negedge clk);
    alu_i = alu; wdata_i = wd; d_mem_i = dm;
    mem_re_i = re; mem_wr_i = wr; mem_f3_i = f3;
    rd_i = rd; reg_we_i = we; stall_i = st;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    alu_i = 0; wdata_i = 0; d_mem_i = 0; mem_re_i = 0; mem_wr_i = 0;
    mem_f3_i = 0; rd_i = 0; reg_we_i = 0; stall_i = 0;
    #12;
    check_eq("rst_wb", wb_data_o, 32'h0);
    check_eq("rst_rd", {27'h0, rd_o}, 32'h0);
    check_eq("rst_we", {31'h0, reg_we_o}, 32'h0);
    check_eq("rst_mis", {31'h0, misalign_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // SB at byte offset 2
    drive(32'h6, 32'hAB, 32'h0, 0, 1, 3'b000, 5'd0, 0, 0);
    check_eq("sb_be", {28'h0, d_mem_be_o}, 32'h4);
    check_eq("sb_wdata", d_mem_wdata_o, 32'hABABABAB);
    check_eq("sb_addr", d_mem_addr_o, 32'h4);
    check_eq("sb_re", {31'h0, d_mem_re_o}, 32'h0);
    tick();
    check_eq("sb_wb", wb_data_o, 32'h6);
    check_eq("sb_mis", {31'h0, misalign_o}, 32'h0);

    // SH upper half, then misaligned SH
    drive(32'h102, 32'h1234CAFE, 32'h0, 0, 1, 3'b001, 5'd0, 0, 0);
    check_eq("sh_be", {28'h0, d_mem_be_o}, 32'hC);
    check_eq("sh_wdata", d_mem_wdata_o, 32'hCAFECAFE);
    check_eq("sh_addr", d_mem_addr_o, 32'h100);
    drive(32'h3, 32'h1234CAFE, 32'h0, 0, 1, 3'b001, 5'd0, 0, 0);
    check_eq("sh_mis_be", {28'h0, d_mem_be_o}, 32'h0);
    tick();
    check_eq("sh_mis_flag", {31'h0, misalign_o}, 32'h1);

    // LB sign-extend
    drive(32'h2, 32'h0, 32'h80FF1234, 1, 0, 3'b000, 5'd3, 1, 0);
    check_eq("lb_re", {31'h0, d_mem_re_o}, 32'h1);
    check_eq("lb_be", {28'h0, d_mem_be_o}, 32'h0);
    tick();
    check_eq("lb_wb", wb_data_o, 32'hFFFFFFFF);
    check_eq("lb_rd", {27'h0, rd_o}, 32'd3);
    check_eq("lb_we", {31'h0, reg_we_o}, 32'h1);
    check_eq("lb_mis", {31'h0, misalign_o}, 32'h0);

    // LBU zero-extend
    drive(32'h2, 32'h0, 32'h80FF1234, 1, 0, 3'b100, 5'd3, 1, 0);
    tick();
    check_eq("lbu_wb", wb_data_o, 32'h000000FF);

    // LH sign-extend upper half
    drive(32'h2, 32'h0, 32'h80001234, 1, 0, 3'b001, 5'd4, 1, 0);
    tick();
    check_eq("lh_wb", wb_data_o, 32'hFFFF8000);

    // LHU lower half
    drive(32'h0, 32'h0, 32'h80009234, 1, 0, 3'b101, 5'd4, 1, 0);
    tick();
    check_eq("lhu_wb", wb_data_o, 32'h00009234);

    // Misaligned LH
    drive(32'h1, 32'h0, 32'h80001234, 1, 0, 3'b001, 5'd4, 1, 0);
    tick();
    check_eq("lh_mis_wb", wb_data_o, 32'h0);
    check_eq("lh_mis_flag", {31'h0, misalign_o}, 32'h1);
    check_eq("lh_mis_we", {31'h0, reg_we_o}, 32'h0);

    // LW aligned
    drive(32'h10, 32'h0, 32'hDEADBEEF, 1, 0, 3'b010, 5'd6, 1, 0);
    tick();
    check_eq("lw_wb", wb_data_o, 32'hDEADBEEF);

    // Non-memory op
    drive(32'h12345678, 32'h0, 32'hFFFFFFFF, 0, 0, 3'b000, 5'd5, 1, 0);
    check_eq("alu_be", {28'h0, d_mem_be_o}, 32'h0);
    check_eq("alu_re", {31'h0, d_mem_re_o}, 32'h0);
    tick();
    check_eq("alu_wb", wb_data_o, 32'h12345678);
    check_eq("alu_rd", {27'h0, rd_o}, 32'd5);
    check_eq("alu_we", {31'h0, reg_we_o}, 32'h1);
    check_eq("alu_mis", {31'h0, misalign_o}, 32'h0);

    // Simultaneous load and store: store wins
    drive(32'h8, 32'h0BADF00D, 32'h55555555, 1, 1, 3'b010, 5'd7, 1, 0);
    check_eq("rw_be", {28'h0, d_mem_be_o}, 32'hF);
    check_eq("rw_re", {31'h0, d_mem_re_o}, 32'h0);
    check_eq("rw_wdata", d_mem_wdata_o, 32'h0BADF00D);
    tick();
    check_eq("rw_wb", wb_data_o, 32'h00000008);
    check_eq("rw_rd", {27'h0, rd_o}, 32'd7);

    // Stall with a new store: no write, registers hold
    drive(32'h55, 32'hAA, 32'h0, 0, 1, 3'b000, 5'd9, 0, 1);
    check_eq("stall_be", {28'h0, d_mem_be_o}, 32'h0);
    tick();
    check_eq("stall_wb", wb_data_o, 32'h8);
    check_eq("stall_rd", {27'h0, rd_o}, 32'd7);
    check_eq("stall_we", {31'h0, reg_we_o}, 32'h1);

    // Reset asserted mid-cycle clears immediately
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_wb", wb_data_o, 32'h0);
    check_eq("arst_rd", {27'h0, rd_o}, 32'h0);
    check_eq("arst_we", {31'h0, reg_we_o}, 32'h0);
    check_eq("arst_mis", {31'h0, misalign_o}, 32'h0);
    check_eq("arst_addr", d_mem_addr_o, 32'h54);

    // First capture after reset release
    drive(32'hCAFE0000, 32'h0, 32'h0, 0, 0, 3'b000, 5'd11, 1, 0);
    rst = 1'b1;
    tick();
    check_eq("post_rst_wb", wb_data_o, 32'hCAFE0000);
    check_eq("post_rst_rd", {27'h0, rd_o}, 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
